// File: rtl/reg_file.sv
// LEGv8 register file: 32 x WORD registers, two combinational read ports, one synchronous write port.
// X31 (XZR) reads as zero. Optional same-cycle write forwarding with REG_FILE_WRITE_BYPASS_EN.
module reg_file #(
    parameter int WORD     = 64,
    parameter int NUM_REGS = 32,
    parameter int ZERO_REG = 31
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      r_reg1,
    input  logic [4:0]      r_reg2,
    input  logic [4:0]      w_reg,
    input  logic [WORD-1:0] w_data,
    input  logic            RegWrite,
    output logic [WORD-1:0] r_data1,
    output logic [WORD-1:0] r_data2
);

    localparam logic [4:0] ZERO_IDX = 5'(ZERO_REG);

    logic [WORD-1:0] r_regs [NUM_REGS];
    logic            w_wr_en;
    logic            w_fwd1;
    logic            w_fwd2;

    assign w_wr_en = RegWrite && (w_reg != ZERO_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[w_reg] <= w_data;
        end
    end

`ifdef REG_FILE_WRITE_BYPASS_EN
    // Forward the in-flight write so a same-cycle read sees the new value.
    assign w_fwd1 = w_wr_en && !rst && (w_reg == r_reg1);
    assign w_fwd2 = w_wr_en && !rst && (w_reg == r_reg2);
`else
    assign w_fwd1 = 1'b0;
    assign w_fwd2 = 1'b0;
`endif

    always_comb begin
        r_data1 = '0;
        r_data2 = '0;
        if (!rst && (r_reg1 != ZERO_IDX)) begin
            r_data1 = w_fwd1 ? w_data : r_regs[r_reg1];
        end
        if (!rst && (r_reg2 != ZERO_IDX)) begin
            r_data2 = w_fwd2 ? w_data : r_regs[r_reg2];
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus pushes expected read values, a monitor checks them at negedge.
module tb_reg_file;

`ifdef REG_FILE_WRITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [4:0]  r_reg1, r_reg2, w_reg;
    logic [63:0] w_data;
    logic        RegWrite;
    logic [63:0] r_data1, r_data2;

    int n_chk  = 0;
    int n_fail = 0;

    logic [63:0] mdl [32];
    string       qn[$];
    logic [63:0] q1[$];
    logic [63:0] q2[$];

    reg_file #(.WORD(64), .NUM_REGS(32), .ZERO_REG(31)) dut (
        .clk     (clk),
        .rst     (rst),
        .r_reg1  (r_reg1),
        .r_reg2  (r_reg2),
        .w_reg   (w_reg),
        .w_data  (w_data),
        .RegWrite(RegWrite),
        .r_data1 (r_data1),
        .r_data2 (r_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: what a read of idx should return right now, given the driven inputs.
    function automatic logic [63:0] exp_rd(input logic [4:0] idx);
        if (rst || idx == 5'd31) return 64'd0;
        if (BYP && RegWrite && w_reg == idx) return w_data;
        return mdl[idx];
    endfunction

    task automatic step(input logic rv, input logic we, input logic [4:0] wr,
                        input logic [63:0] wd, input logic [4:0] a,
                        input logic [4:0] b, input string nm);
        rst = rv; RegWrite = we; w_reg = wr; w_data = wd; r_reg1 = a; r_reg2 = b;
        if (rv) foreach (mdl[i]) mdl[i] = 64'd0;
        qn.push_back(nm);
        q1.push_back(exp_rd(a));
        q2.push_back(exp_rd(b));
        @(posedge clk);
        if (!rv && we && wr != 5'd31) mdl[wr] = wd;
        #1;
    endtask

    // Monitor: the read ports are valid every cycle; check at the falling edge.
    initial begin
        string nm;
        logic [63:0] e1, e2;
        forever begin
            @(negedge clk);
            if (qn.size() > 0) begin
                nm = qn.pop_front(); e1 = q1.pop_front(); e2 = q2.pop_front();
                n_chk++;
                if (r_data1 !== e1) begin
                    n_fail++;
                    $display("FAIL %s r_data1: got %0h expected %0h", nm, r_data1, e1);
                end
                n_chk++;
                if (r_data2 !== e2) begin
                    n_fail++;
                    $display("FAIL %s r_data2: got %0h expected %0h", nm, r_data2, e2);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; RegWrite = 1'b0; w_reg = '0; w_data = '0; r_reg1 = '0; r_reg2 = '0;
        foreach (mdl[i]) mdl[i] = 64'd0;
        repeat (2) @(posedge clk);
        #1;

        step(1, 0, 0, 0, 31, 30, "rst_31_30");
        step(1, 0, 0, 0, 20, 30, "rst_20");
        step(0, 0, 0, 0,  0, 20, "post_rst_0");

        step(0, 1, 11, 64'd100, 0, 0, "wr_x11");
        step(0, 0, 11, 64'd0, 11, 0, "rd_x11");
        step(0, 1, 1, 64'd123456789, 11, 1, "wr_x1");
        step(0, 0, 0, 64'd0, 11, 1, "rd_x1_x11");

        step(0, 1, 31, 64'hDEADBEEF, 31, 31, "wr_xzr");
        step(0, 0, 31, 64'hDEADBEEF, 31, 11, "rd_xzr");
        step(0, 0, 5, 64'd7, 5, 5, "we0_x5");
        step(0, 0, 0, 64'd0, 5, 1, "rd_x5");

        step(0, 1, 3, 64'd55, 3, 3, "wr_x3");
        step(0, 0, 0, 64'd0, 3, 11, "rd_x3");
        step(1, 0, 0, 64'd0, 3, 11, "async_rst");
        step(0, 0, 0, 64'd0, 3, 11, "after_rst");

        // Reset pulse entirely between edges must still clear storage.
        step(0, 1, 9, 64'hABCD, 9, 9, "wr_x9");
        rst = 1'b1; #2; rst = 1'b0;
        foreach (mdl[i]) mdl[i] = 64'd0;
        #1;
        step(0, 0, 0, 64'd0, 9, 9, "rst_glitch_x9");

        step(0, 1, 7, 64'd4, 0, 0, "wr_x7_4");
        step(0, 1, 7, 64'd9, 7, 7, "same_cycle_pre");
        step(0, 0, 0, 64'd0, 7, 7, "same_cycle_post");

        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 39) == 0), $urandom_range(0, 1),
                 5'($urandom_range(0, 31)), {$urandom, $urandom},
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), "random");
        end

        for (int k = 0; k < 5 && qn.size() > 0; k++) @(posedge clk);
        n_chk++;
        if (qn.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d pending, expected 0", qn.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
